// File: rtl/i2s_rx_ctrl.sv
// I2S receive master: generates bclk/lrclk from clk and deserialises the ADC
// slot words, presenting each completed word with a one-clk valid pulse.
module i2s_rx_ctrl #(
    parameter int unsigned BCLK_DIV = 4  // clk cycles per bclk half-period, 2..255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        sdata,
    output logic        bclk,
    output logic        lrclk,
    output logic [31:0] adc_data,
    output logic        adc_valid,
    output logic        adc_chan,
    output logic        busy
);

    localparam int unsigned DIV_W  = 8;
    localparam int unsigned BIT_W  = 5;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t              state_q;
    logic [DIV_W-1:0]    div_cnt_q;
    logic [BIT_W-1:0]    bit_cnt_q;
    logic                bclk_q;
    logic                lrclk_q;
    logic [WORD_W-1:0]   sr_q;
    logic [WORD_W-1:0]   sr_d;
    logic [WORD_W-1:0]   adc_data_q;
    logic                adc_valid_q;
    logic                adc_chan_q;
    logic                busy_q;
    logic                cap_q;    // capture point seen on the previous clk
    logic                first_q;  // next capture point is the dummy one after start
    logic                done_q;   // right-slot word emitted while stopping

    logic div_wrap;
    logic bclk_rise;
    logic bclk_fall;

    assign div_wrap  = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
    assign bclk_rise = div_wrap & ~bclk_q;
    assign bclk_fall = div_wrap & bclk_q;
    assign sr_d      = {sr_q[WORD_W-2:0], sdata};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            bit_cnt_q   <= '0;
            bclk_q      <= 1'b0;
            lrclk_q     <= 1'b0;
            sr_q        <= '0;
            adc_data_q  <= '0;
            adc_valid_q <= 1'b0;
            adc_chan_q  <= 1'b0;
            busy_q      <= 1'b0;
            cap_q       <= 1'b0;
            first_q     <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            adc_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        first_q <= 1'b1;
                        cap_q   <= 1'b0;
                        done_q  <= 1'b0;
                    end
                end
                RUN, STOP: begin
                    if (done_q) begin
                        // back to a quiet bus with counters cleared for the next start
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                        div_cnt_q <= '0;
                        bit_cnt_q <= '0;
                        bclk_q    <= 1'b0;
                        lrclk_q   <= 1'b0;
                        cap_q     <= 1'b0;
                        done_q    <= 1'b0;
                    end else begin
                        div_cnt_q <= div_wrap ? '0 : div_cnt_q + DIV_W'(1);
                        if (div_wrap) begin
                            bclk_q <= ~bclk_q;
                        end
                        if (bclk_fall) begin
                            bit_cnt_q <= bit_cnt_q + BIT_W'(1);
                            if (bit_cnt_q == BIT_W'(31)) begin
                                lrclk_q <= ~lrclk_q;
                            end
                        end
                        if (bclk_rise) begin
                            sr_q <= sr_d;
                        end
                        // bit 0 of a slot carries the LSB of the previous slot's word
                        cap_q <= bclk_rise && (bit_cnt_q == '0);
                        if (cap_q) begin
                            if (first_q) begin
                                first_q <= 1'b0;
                            end else begin
                                adc_data_q  <= sr_q;
                                adc_chan_q  <= ~lrclk_q;
                                adc_valid_q <= 1'b1;
                            end
                            if ((state_q == STOP) && !lrclk_q) begin
                                done_q <= 1'b1;
                            end
                        end
                        if ((state_q == RUN) && !enable) begin
                            state_q <= STOP;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bclk      = bclk_q;
    assign lrclk     = lrclk_q;
    assign adc_data  = adc_data_q;
    assign adc_valid = adc_valid_q;
    assign adc_chan  = adc_chan_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// Bench for i2s_rx_ctrl: two instances (BCLK_DIV 4 and 2), an I2S ADC slave model,
// a frame-arithmetic reference model and directed timing/data scenarios.
module tb_i2s_rx_ctrl;

    localparam int unsigned NW = 320;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  rst_n_v;
    logic [1:0]  en_v;
    logic [1:0]  sd_v;
    logic [1:0]  bclk_w;
    logic [1:0]  lrclk_w;
    logic [1:0]  valid_w;
    logic [1:0]  chan_w;
    logic [1:0]  busy_w;
    logic [31:0] data_w [2];

    i2s_rx_ctrl #(.BCLK_DIV(4)) u_div4 (
        .clk(clk), .reset_n(rst_n_v[0]), .enable(en_v[0]), .sdata(sd_v[0]),
        .bclk(bclk_w[0]), .lrclk(lrclk_w[0]), .adc_data(data_w[0]),
        .adc_valid(valid_w[0]), .adc_chan(chan_w[0]), .busy(busy_w[0])
    );

    i2s_rx_ctrl #(.BCLK_DIV(2)) u_div2 (
        .clk(clk), .reset_n(rst_n_v[1]), .enable(en_v[1]), .sdata(sd_v[1]),
        .bclk(bclk_w[1]), .lrclk(lrclk_w[1]), .adc_data(data_w[1]),
        .adc_valid(valid_w[1]), .adc_chan(chan_w[1]), .busy(busy_w[1])
    );

    int errors = 0;
    int checks = 0;
    logic [31:0] rnd [NW];

    // reference model: mode 0 idle, 1 run, 2 stop; m_c counts clks since start
    int          m_mode [2];
    int          m_c [2];
    logic        m_idle_next [2];
    logic        e_busy [2];
    logic        e_bclk [2];
    logic        e_lr [2];
    logic        e_valid [2];
    logic        e_chan [2];
    logic [31:0] e_data [2];

    // ADC slave state
    int   a_slot [2];
    int   a_pos [2];
    logic a_bclk [2];
    logic a_lr [2];
    logic a_busy [2];

    function automatic int div_of(input int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic logic [31:0] word_of(input int i, input int s);
        logic [31:0] base;
        if (i != 0) return rnd[s % int'(NW)];
        base = (s % 2 == 0) ? 32'hA5A5_0F0F : 32'h1234_5678;
        return base ^ (32'(s / 2) * 32'h0001_0001);
    endfunction

    task automatic chk(input int i, input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s u%0d @%0t: got %h expected %h", name, i, $time, act, exp);
        end
    endtask

    task automatic model_step();
        for (int i = 0; i < 2; i++) begin
            int d;
            int fr;
            int j;
            d  = div_of(i);
            fr = 64 * d;
            e_valid[i] = 1'b0;
            if (!rst_n_v[i]) begin
                m_mode[i] = 0;
                m_idle_next[i] = 1'b0;
                e_data[i] = '0;
                e_chan[i] = 1'b0;
            end else if (m_mode[i] == 0) begin
                if (en_v[i]) begin
                    m_mode[i] = 1;
                    m_c[i] = 0;
                end
            end else if (m_idle_next[i]) begin
                m_mode[i] = 0;
                m_idle_next[i] = 1'b0;
            end else begin
                m_c[i]++;
                if (m_c[i] > d && (m_c[i] - d - 1) % fr == 0) begin
                    j = (m_c[i] - d - 1) / fr;
                    if (j >= 1) begin
                        e_valid[i] = 1'b1;
                        e_data[i]  = word_of(i, j - 1);
                        e_chan[i]  = ((j - 1) % 2) != 0;
                    end
                    if (m_mode[i] == 2 && j % 2 == 0) m_idle_next[i] = 1'b1;
                end
                if (m_mode[i] == 1 && !en_v[i]) m_mode[i] = 2;
            end
            e_busy[i] = (m_mode[i] != 0);
            e_bclk[i] = (m_mode[i] != 0) && (((m_c[i] / d) % 2) != 0);
            e_lr[i]   = (m_mode[i] != 0) && (((m_c[i] / fr) % 2) != 0);
        end
    endtask

    task automatic adc_step();
        logic [31:0] w;
        for (int i = 0; i < 2; i++) begin
            if (busy_w[i] && !a_busy[i]) begin
                a_slot[i] = 0;
                a_pos[i]  = 0;
                sd_v[i]   = 1'b0;
            end else if (busy_w[i] && a_bclk[i] && !bclk_w[i]) begin
                if (lrclk_w[i] != a_lr[i]) begin
                    a_slot[i]++;
                    a_pos[i] = 0;
                    w = word_of(i, a_slot[i] - 1);
                    sd_v[i] = w[0];
                end else begin
                    a_pos[i]++;
                    w = word_of(i, a_slot[i]);
                    sd_v[i] = w[(32 - a_pos[i]) & 31];
                end
            end
            a_bclk[i] = bclk_w[i];
            a_lr[i]   = lrclk_w[i];
            a_busy[i] = busy_w[i];
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            chk(i, "busy",  32'(busy_w[i]),  32'(e_busy[i]));
            chk(i, "bclk",  32'(bclk_w[i]),  32'(e_bclk[i]));
            chk(i, "lrclk", 32'(lrclk_w[i]), 32'(e_lr[i]));
            chk(i, "valid", 32'(valid_w[i]), 32'(e_valid[i]));
            chk(i, "chan",  32'(chan_w[i]),  32'(e_chan[i]));
            chk(i, "data",  data_w[i],       e_data[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        adc_step();
        compare_all();
    endtask

    initial begin
        int np;
        int last;
        int n_idle;
        int ch0;
        int ch1;
        int spurious;

        for (int k = 0; k < int'(NW); k++) rnd[k] = $urandom;
        for (int i = 0; i < 2; i++) begin
            m_mode[i] = 0; m_c[i] = 0; m_idle_next[i] = 1'b0;
            e_busy[i] = 1'b0; e_bclk[i] = 1'b0; e_lr[i] = 1'b0;
            e_valid[i] = 1'b0; e_chan[i] = 1'b0; e_data[i] = '0;
            a_slot[i] = 0; a_pos[i] = 0; a_bclk[i] = 1'b0; a_lr[i] = 1'b0; a_busy[i] = 1'b0;
        end
        rst_n_v = 2'b00;
        en_v    = 2'b00;
        sd_v    = 2'b00;

        repeat (3) tick();
        chk(0, "rst_busy", 32'(busy_w[0]), 32'd0);
        chk(0, "rst_data", data_w[0], 32'd0);
        rst_n_v[0] = 1'b1;
        repeat (3) tick();

        // start timing and first two words
        en_v[0] = 1'b1;
        for (int n = 1; n <= 1123; n++) begin
            tick();
            if (n == 1)   chk(0, "a_busy_t1", 32'(busy_w[0]), 32'd1);
            if (n == 4)   chk(0, "a_bclk_t4", 32'(bclk_w[0]), 32'd0);
            if (n == 5)   chk(0, "a_bclk_t5", 32'(bclk_w[0]), 32'd1);
            if (n == 256) chk(0, "a_lr_t256", 32'(lrclk_w[0]), 32'd0);
            if (n == 261) begin
                chk(0, "a_lr_t261", 32'(lrclk_w[0]), 32'd1);
                chk(0, "a_valid_t261", 32'(valid_w[0]), 32'd0);
            end
            if (n == 262) begin
                chk(0, "a_valid_t262", 32'(valid_w[0]), 32'd1);
                chk(0, "a_data_left", data_w[0], 32'hA5A5_0F0F);
                chk(0, "a_chan_left", 32'(chan_w[0]), 32'd0);
            end
            if (n == 518) begin
                chk(0, "a_valid_t518", 32'(valid_w[0]), 32'd1);
                chk(0, "a_data_right", data_w[0], 32'h1234_5678);
                chk(0, "a_chan_right", 32'(chan_w[0]), 32'd1);
            end
        end

        // stop requested mid-left-slot: one more left/right pair
        en_v[0] = 1'b0;
        np = 0; last = -1; n_idle = -1; ch0 = -1; ch1 = -1;
        for (int n = 1; n <= 1400; n++) begin
            tick();
            if (valid_w[0]) begin
                if (np == 0) ch0 = int'(chan_w[0]);
                else if (np == 1) ch1 = int'(chan_w[0]);
                np++;
                last = n;
            end
            if (!busy_w[0]) begin
                n_idle = n;
                break;
            end
        end
        chk(0, "b_pulses", 32'(np), 32'd2);
        chk(0, "b_chan_first", 32'(ch0), 32'd0);
        chk(0, "b_chan_second", 32'(ch1), 32'd1);
        chk(0, "b_idle_gap", 32'(n_idle - last), 32'd1);
        chk(0, "b_idle_bclk", 32'(bclk_w[0]), 32'd0);
        chk(0, "b_idle_lrclk", 32'(lrclk_w[0]), 32'd0);

        // enable re-raised during STOP must not restart early
        en_v[0] = 1'b1;
        tick();
        chk(0, "c_busy_start", 32'(busy_w[0]), 32'd1);
        repeat (100) tick();
        en_v[0] = 1'b0;
        repeat (50) tick();
        en_v[0] = 1'b1;
        np = 0; last = -1; n_idle = -1; ch0 = -1; ch1 = -1;
        for (int n = 1; n <= 1000; n++) begin
            tick();
            if (valid_w[0]) begin
                if (np == 0) ch0 = int'(chan_w[0]);
                else if (np == 1) ch1 = int'(chan_w[0]);
                np++;
                last = n;
            end
            if (!busy_w[0]) begin
                n_idle = n;
                break;
            end
        end
        chk(0, "c_pulses", 32'(np), 32'd2);
        chk(0, "c_chan_first", 32'(ch0), 32'd0);
        chk(0, "c_chan_second", 32'(ch1), 32'd1);
        chk(0, "c_idle_gap", 32'(n_idle - last), 32'd1);
        tick();
        chk(0, "c_restart_busy", 32'(busy_w[0]), 32'd1);
        for (int m = 1; m <= 393; m++) begin
            tick();
            if (m == 260) chk(0, "c_valid_early", 32'(valid_w[0]), 32'd0);
            if (m == 261) begin
                chk(0, "c_valid_first", 32'(valid_w[0]), 32'd1);
                chk(0, "c_chan_first_word", 32'(chan_w[0]), 32'd0);
                chk(0, "c_data_first_word", data_w[0], 32'hA5A5_0F0F);
            end
        end

        // reset pulse at bit 17 of the right slot
        rst_n_v[0] = 1'b0;
        #1;
        chk(0, "d_async_busy",  32'(busy_w[0]),  32'd0);
        chk(0, "d_async_bclk",  32'(bclk_w[0]),  32'd0);
        chk(0, "d_async_lrclk", 32'(lrclk_w[0]), 32'd0);
        chk(0, "d_async_valid", 32'(valid_w[0]), 32'd0);
        chk(0, "d_async_chan",  32'(chan_w[0]),  32'd0);
        chk(0, "d_async_data",  data_w[0],       32'd0);
        tick();
        rst_n_v[0] = 1'b1;
        spurious = 0;
        for (int n = 1; n <= 262; n++) begin
            tick();
            if (n == 1) chk(0, "d_busy_t1", 32'(busy_w[0]), 32'd1);
            if (n < 262 && valid_w[0]) spurious++;
            if (n == 262) begin
                chk(0, "d_valid_t262", 32'(valid_w[0]), 32'd1);
                chk(0, "d_chan_t262", 32'(chan_w[0]), 32'd0);
                chk(0, "d_data_t262", data_w[0], 32'hA5A5_0F0F);
            end
        end
        chk(0, "d_spurious", 32'(spurious), 32'd0);
        en_v[0] = 1'b0;
        for (int n = 1; n <= 1500; n++) begin
            tick();
            if (!busy_w[0]) break;
        end
        chk(0, "d_stop_done", 32'(busy_w[0]), 32'd0);

        // BCLK_DIV = 2 random stream
        rst_n_v[1] = 1'b1;
        tick();
        en_v[1] = 1'b1;
        np = 0; last = -1;
        for (int n = 1; n <= 35972; n++) begin
            tick();
            if (valid_w[1]) begin
                if (last >= 0) chk(1, "e_spacing", 32'(n - last), 32'd128);
                else chk(1, "e_first_at", 32'(n), 32'd132);
                if (np == 0) begin
                    chk(1, "e_data_w0", data_w[1], rnd[0]);
                    chk(1, "e_chan_w0", 32'(chan_w[1]), 32'd0);
                end
                if (np == 1) begin
                    chk(1, "e_data_w1", data_w[1], rnd[1]);
                    chk(1, "e_chan_w1", 32'(chan_w[1]), 32'd1);
                end
                np++;
                last = n;
            end
        end
        chk(1, "e_pulses", 32'(np), 32'd281);
        en_v[1] = 1'b0;
        for (int n = 1; n <= 800; n++) begin
            tick();
            if (!busy_w[1]) break;
        end
        chk(1, "e_stop_done", 32'(busy_w[1]), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
